four_bit_serial_subtractor: RTL and testbench
=============================================

# four_bit_serial_subtractor

Bit-serial 4-bit unsigned subtractor: the inverse of the combinational ripple adder in the datapath. It computes a − b one bit per cycle through a single full-subtractor cell and a registered borrow, producing a 5-bit result: 4-bit difference plus borrow-out. It sits beside the adder in the FPGA arithmetic test design as a small start/done coprocessor, and is the template for later multi-cycle ALU ops.

## Interface
- WIDTH, 4: operand width; fixed at 4 for this block, other values unsupported.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  4  minuend; captured on accepted start.
- b  in  4  subtrahend; captured on accepted start.
- busy  out  1  high while bits are being processed (SHIFT).
- done  out  1  one-cycle pulse when the result becomes valid.
- d  out  5  result: d[3:0] = (a − b) mod 16; d[4] = borrow = (a < b unsigned). Held until the next result.
- ovf  out  1  signed overflow; present only with SUB_OVERFLOW_EN.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → latch a, b into shift registers; borrow reg ← 0; bit count ← 0; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, one bit per cycle, LSB first:
  - diff_i = a_i ^ b_i ^ bin.
  - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
  - diff_i shifts into the result register MSB side; borrow reg ← bout; count++.
  - After bit 3 (count==3): load d ← {bout, result}; go to DONE.
- DONE: done=1 for this cycle only; go to IDLE.
- start outside IDLE (SHIFT or DONE) is ignored, not queued. Operands a/b are don't-care outside the accepting cycle.
- d changes only on the SHIFT→DONE transition. Partial results are never visible on d.
- Reset mid-operation: next cycle state=IDLE, busy=0, done=0, d=0; the in-flight computation is discarded.
- Reset values: busy=0, done=0, d=5'b00000, ovf=0, state=IDLE, internal regs 0.

## Timing
- Latency:
  - Start sampled high at the end of cycle N.
  - busy=1 in cycles N+1..N+4.
  - done=1 and d valid in cycle N+5.
  - Earliest next accepted start is in cycle N+6 (IDLE).
- Throughput: one operation per 6 cycles when start is held high.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- busy and done are never both high.

## Configuration
- SUB_OVERFLOW_EN defined:
  - ovf port exists.
  - ovf = (a[3] != b[3]) && (d[3] != a[3]), using the captured a/b.
  - ovf is registered and updated together with d; reset value 0.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package arith_pkg:
  - SUB_WIDTH = 4.
  - sub_state_t enum {IDLE, SHIFT, DONE}.
  - BIT_CNT_W = 2.
- Sub-module full_subtractor(a, b, bin, d, bout): combinational single-bit cell, the counterpart of the existing full-adder cell. It is instantiated once and reused every cycle.

## Test plan
- a=9, b=3, start pulse → busy 4 cycles, then done pulse with d=5'b00110; ovf=0.
- a=3, b=9 → d=5'b11010 (diff 10, borrow 1); ovf=0.
- a=7, b=8 (SUB_OVERFLOW_EN) → d=5'b11111, ovf=1. Then a=0, b=0 → d=0, ovf=0.
- start held high for 20 cycles with a=15, b=0 → done every 6 cycles, d=5'b01111 each time. Operand changes during busy do not affect results.
- start accepted, reset asserted during 2nd busy cycle → next cycle busy=0, done=0, d=0. A subsequent a=5, b=5 completes normally with d=0, done after 5 cycles.
- Exhaustive sweep of all 256 a/b pairs → d matches {a<b, (a−b)&4'hF} for every pair; busy/done protocol is checked by assertions.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial subtractor and its bit cell.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package arith_pkg;

  localparam int SUB_WIDTH = 4;
  localparam int BIT_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of one column.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: d = {a<b, (a-b) mod 16}, LSB first through one cell.
// Latency: start accepted in cycle N -> busy N+1..N+4, done pulse and d valid in N+5.
// Backpressure: start only sampled in IDLE; start in SHIFT/DONE is dropped, not queued.
// Optional macro SUB_OVERFLOW_EN adds a registered signed-overflow output ovf.
module four_bit_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   d
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  sub_state_t           state;
  logic [WIDTH-1:0]     a_sr;
  logic [WIDTH-1:0]     b_sr;
  // Only the lower WIDTH-1 difference bits need storing; the top bit comes
  // straight from the cell on the final cycle.
  logic [WIDTH-2:0]     res;
  logic                 bin;
  logic [BIT_CNT_W-1:0] cnt;
  logic                 diff;
  logic                 bout;

  // One shared cell, fed by the operand LSBs and the registered borrow.
  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin),
    .d    (diff),
    .bout (bout)
  );

  // Control FSM and datapath: capture, shift one bit per cycle, publish result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      bin   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
`ifdef SUB_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            res   <= '0;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          res  <= {diff, res[WIDTH-2:1]};
          bin  <= bout;
          cnt  <= cnt + 1'b1;
          if (cnt == BIT_CNT_W'(WIDTH - 1)) begin
            // Sign bits of both operands are in the LSB slots right now.
            d     <= {bout, diff, res};
`ifdef SUB_OVERFLOW_EN
            ovf   <= (a_sr[0] != b_sr[0]) && (diff != a_sr[0]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Directed bench for four_bit_serial_subtractor; ovf checks only with SUB_OVERFLOW_EN.
module tb_four_bit_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [4:0] d;
`ifdef SUB_OVERFLOW_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit in_reset = 1'b1;

  always #5 clk = ~clk;

  four_bit_serial_subtractor dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  // busy and done must never overlap
  always @(negedge clk) begin
    if (!in_reset) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b, required not both high", busy, done);
      end
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the first busy cycle (1) to the done cycle; bounded.
  task wait_done(output int cyc, output int nbusy);
    cyc   = 1;
    nbusy = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
      if (busy) nbusy++;
    end
  endtask

  task test_reset;
    reset = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b d=%b, required 0 0 00000", busy, done, d);
    end
`ifdef SUB_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
    end
`endif
    reset = 1'b0;
    in_reset = 1'b0;
    tick();
  endtask

  task test_sub_9_3;
    a = 4'd9; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; a = 4'hF; b = 4'hF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || d !== 5'b00000) begin
        errors++;
        $display("FAIL sub93_busy_cycle%0d: busy=%b done=%b d=%b, required 1 0 00000", i, busy, done, d);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || d !== 5'b00110) begin
      errors++;
      $display("FAIL sub93_result: done=%b busy=%b d=%b, required 1 0 00110", done, busy, d);
    end
`ifdef SUB_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub93_ovf: ovf=%b, required 0", ovf);
    end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || d !== 5'b00110) begin
      errors++;
      $display("FAIL sub93_after: done=%b d=%b, required 0 00110", done, d);
    end
  endtask

  task test_borrow;
    int cyc, nb;
    a = 4'd3; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nb);
    checks++;
    if (d !== 5'b11010 || cyc != 5 || nb != 4) begin
      errors++;
      $display("FAIL sub39: d=%b cyc=%0d busy_cycles=%0d, required 11010 5 4", d, cyc, nb);
    end
`ifdef SUB_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub39_ovf: ovf=%b, required 0", ovf);
    end
`endif
    tick();
  endtask

  task test_overflow;
    int cyc, nb;
    a = 4'd7; b = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nb);
    checks++;
    if (d !== 5'b11111 || cyc != 5) begin
      errors++;
      $display("FAIL sub78: d=%b cyc=%0d, required 11111 5", d, cyc);
    end
`ifdef SUB_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub78_ovf: ovf=%b, required 1", ovf);
    end
`endif
    tick(); tick(); tick();
    checks++;
    if (d !== 5'b11111 || done !== 1'b0) begin
      errors++;
      $display("FAIL sub78_hold: d=%b done=%b, required 11111 0", d, done);
    end
    a = 4'd0; b = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nb);
    checks++;
    if (d !== 5'b00000 || cyc != 5) begin
      errors++;
      $display("FAIL sub00: d=%b cyc=%0d, required 00000 5", d, cyc);
    end
`ifdef SUB_OVERFLOW_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub00_ovf: ovf=%b, required 0", ovf);
    end
`endif
    tick();
  endtask

  task test_back_to_back;
    int ndone, last, gap_bad;
    ndone = 0; last = -1; gap_bad = 0;
    a = 4'd15; b = 4'd0; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        ndone++;
        checks++;
        if (d !== 5'b01111) begin
          errors++;
          $display("FAIL b2b_result_cycle%0d: d=%b, required 01111", i, d);
        end
        if (last >= 0 && i - last != 6) gap_bad++;
        last = i;
      end
      if (busy) begin
        a = 4'd2; b = 4'd13;
      end else begin
        a = 4'd15; b = 4'd0;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3 || gap_bad != 0 || last != 17) begin
      errors++;
      $display("FAIL b2b_cadence: dones=%0d bad_gaps=%0d last=%0d, required 3 0 17", ndone, gap_bad, last);
    end
    tick(); tick(); tick();
  endtask

  task test_reset_mid_op;
    int cyc, nb;
    a = 4'd9; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    in_reset = 1'b1;
    tick();
    reset = 1'b0;
    in_reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 5'b00000) begin
      errors++;
      $display("FAIL midreset: busy=%b done=%b d=%b, required 0 0 00000", busy, done, d);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard: busy=%b done=%b, required 0 0", busy, done);
    end
    a = 4'd5; b = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nb);
    checks++;
    if (d !== 5'b00000 || cyc != 5 || nb != 4 || done !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_55: d=%b cyc=%0d busy_cycles=%0d done=%b, required 00000 5 4 1", d, cyc, nb, done);
    end
    tick();
  endtask

  task test_sweep;
    int cyc, nb;
    logic [4:0] expd;
    logic [3:0] diff;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        a = 4'(ia); b = 4'(ib); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, nb);
        diff = 4'(ia - ib);
        expd = {(ia < ib) ? 1'b1 : 1'b0, diff};
        checks++;
        if (d !== expd || cyc != 5 || nb != 4) begin
          errors++;
          $display("FAIL sweep a=%0d b=%0d: d=%b cyc=%0d busy_cycles=%0d, required %b 5 4", ia, ib, d, cyc, nb, expd);
        end
`ifdef SUB_OVERFLOW_EN
        checks++;
        if (ovf !== ((a[3] != b[3]) && (diff[3] != a[3]))) begin
          errors++;
          $display("FAIL sweep_ovf a=%0d b=%0d: ovf=%b, required %b", ia, ib, ovf, (a[3] != b[3]) && (diff[3] != a[3]));
        end
`endif
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub_9_3();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
